// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Shares the single-port instruction memory between the fetch unit
//   (read-only) and the loader/debug port (read or write). Round-robin
//   arbitration through a two-phase FSM: ARB samples requests and latches the
//   winner's command, ACCESS drives the memory for one cycle and captures the
//   read data. The done pulse and read data appear the cycle after ACCESS.
//
//   Optional build macro IMEM_ARB_LOCK_EN adds input l_lock. While l_lock is
//   high, fetch requests are ignored during arbitration.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   f_req, f_addr               fetch read request and address
//   f_gnt, f_done, f_rdata      fetch grant pulse, done pulse, read data
//   l_req, l_we, l_addr, l_wdata  loader request, write enable, address, data
//   l_lock                      (IMEM_ARB_LOCK_EN only) hold off fetch
//   l_gnt, l_done, l_rdata      loader grant pulse, done pulse, read data
//   mem_addr, mem_wdata         memory address / write data (0 outside ACCESS)
//   mem_we, mem_re              memory write / read enable
//   mem_rdata                   memory read data (combinational read)
//   f_stall_cnt                 saturating count of stalled fetch cycles
//
// state  | meaning
// ARB    | idle or choosing the next winner; latch its command
// ACCESS | memory access for the latched winner; gnt pulses here
module imem_access_arbiter #(
  parameter int ADDR_W  = 65,
  parameter int DATA_W  = 65,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_req,
  input  logic [ADDR_W-1:0]  f_addr,
  output logic               f_gnt,
  output logic               f_done,
  output logic [DATA_W-1:0]  f_rdata,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [ADDR_W-1:0]  l_addr,
  input  logic [DATA_W-1:0]  l_wdata,
`ifdef IMEM_ARB_LOCK_EN
  input  logic               l_lock,
`endif
  output logic               l_gnt,
  output logic               l_done,
  output logic [DATA_W-1:0]  l_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STALL_W-1:0] f_stall_cnt
);

  localparam logic ST_ARB     = 1'b0;
  localparam logic ST_ACCESS  = 1'b1;
  localparam logic WIN_FETCH  = 1'b0;
  localparam logic WIN_LOADER = 1'b1;

  logic              state;
  logic              winner;
  logic              last_winner;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              lock_active;
  logic              f_cand;
  logic              pick_loader;
  logic              in_access;

`ifdef IMEM_ARB_LOCK_EN
  assign lock_active = l_lock;
`else
  assign lock_active = 1'b0;
`endif

  // Loader wins when it is the only candidate or when fetch won last time.
  assign f_cand      = f_req & ~lock_active;
  assign pick_loader = l_req & (~f_cand | (last_winner == WIN_FETCH));

  assign in_access = (state == ST_ACCESS);
  assign f_gnt     = in_access & (winner == WIN_FETCH);
  assign l_gnt     = in_access & (winner == WIN_LOADER);
  assign mem_addr  = in_access ? lat_addr  : '0;
  assign mem_wdata = in_access ? lat_wdata : '0;
  assign mem_we    = in_access & lat_we;
  assign mem_re    = in_access & ~lat_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ARB;
      winner      <= WIN_FETCH;
      last_winner <= WIN_LOADER;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_we      <= 1'b0;
      f_done      <= 1'b0;
      l_done      <= 1'b0;
      f_rdata     <= '0;
      l_rdata     <= '0;
    end else begin
      f_done <= 1'b0;
      l_done <= 1'b0;
      case (state)
        ST_ARB: begin
          if (f_cand || l_req) begin
            state       <= ST_ACCESS;
            winner      <= pick_loader;
            last_winner <= pick_loader;
            lat_addr    <= pick_loader ? l_addr : f_addr;
            // Fetch is read-only: its latched write enable is always 0.
            lat_we      <= pick_loader & l_we;
            lat_wdata   <= pick_loader ? l_wdata : '0;
          end
        end
        default: begin
          state <= ST_ARB;
          if (winner == WIN_LOADER) begin
            l_done  <= 1'b1;
            l_rdata <= lat_we ? '0 : mem_rdata;
          end else begin
            f_done  <= 1'b1;
            f_rdata <= mem_rdata;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_stall_cnt <= '0;
    end else if (f_req && !f_gnt && (f_stall_cnt != {STALL_W{1'b1}})) begin
      f_stall_cnt <= f_stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
module tb_imem_access_arbiter;

  localparam int ADDR_W  = 65;
  localparam int DATA_W  = 65;
  localparam int STALL_W = 4;

  logic               clk;
  logic               rst_n;
  logic               f_req;
  logic [ADDR_W-1:0]  f_addr;
  logic               f_gnt;
  logic               f_done;
  logic [DATA_W-1:0]  f_rdata;
  logic               l_req;
  logic               l_we;
  logic [ADDR_W-1:0]  l_addr;
  logic [DATA_W-1:0]  l_wdata;
  logic               l_lock;
  logic               l_gnt;
  logic               l_done;
  logic [DATA_W-1:0]  l_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [DATA_W-1:0]  mem_rdata;
  logic [STALL_W-1:0] f_stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  imem_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
`ifdef IMEM_ARB_LOCK_EN
    .l_lock(l_lock),
`endif
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .f_stall_cnt(f_stall_cnt)
  );

  // Instruction memory model: word index is addr[8:1], combinational read.
  logic [DATA_W-1:0] mem [0:255] = '{default: '0};
  logic              mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      mem[2]     <= 'hABCD;
      mem[16]    <= 'h77;
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[8:1]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[8:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Contention table: index = cycle after both requests go high.
  logic [7:0] ct_fgnt  = 8'b0010_0010;
  logic [7:0] ct_lgnt  = 8'b1000_1000;
  logic [7:0] ct_fdone = 8'b0100_0100;
  logic [7:0] ct_ldone = 8'b0001_0000;
  int         ct_stall [8] = '{0, 1, 1, 2, 3, 4, 4, 5};

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_lock = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", f_stall_cnt, 0);
    chk("rst_f_done", f_done, 0);
    step();
    rst_n = 1'b1;

    // Fetch only: word 2 at byte address 0x4.
    @(negedge clk);
    f_req = 1'b1; f_addr = 'h4;
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("f1_gnt", f_gnt, 1);
    chk("f1_l_gnt", l_gnt, 0);
    chk("f1_mem_re", mem_re, 1);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_mem_addr", mem_addr, 'h4);
    step();
    @(negedge clk);
    chk("f1_done", f_done, 1);
    chk("f1_rdata", f_rdata, 'hABCD);
    chk("f1_gnt_gone", f_gnt, 0);
    chk("f1_mem_re_gone", mem_re, 0);
    chk("f1_stall", f_stall_cnt, 1);

    // Loader write 0x55 to 0x10.
    l_req = 1'b1; l_we = 1'b1; l_addr = 'h10; l_wdata = 'h55;
    step();
    l_req = 1'b0;
    @(negedge clk);
    chk("lw_gnt", l_gnt, 1);
    chk("lw_f_gnt", f_gnt, 0);
    chk("lw_mem_we", mem_we, 1);
    chk("lw_mem_re", mem_re, 0);
    chk("lw_mem_addr", mem_addr, 'h10);
    chk("lw_mem_wdata", mem_wdata, 'h55);
    step();
    @(negedge clk);
    chk("lw_done", l_done, 1);
    chk("lw_rdata", l_rdata, 0);
    chk("lw_mem_we_gone", mem_we, 0);
    chk("lw_mem_word", mem[8], 'h55);

    // Fetch back the written word.
    l_we = 1'b0;
    f_req = 1'b1; f_addr = 'h10;
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("f2_gnt", f_gnt, 1);
    chk("f2_mem_addr", mem_addr, 'h10);
    step();
    @(negedge clk);
    chk("f2_done", f_done, 1);
    chk("f2_rdata", f_rdata, 'h55);
    chk("f2_stall", f_stall_cnt, 2);

    // Long contention drives the stall counter into saturation.
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 'h4; f_addr = 'h10;
    repeat (40) step();
    f_req = 1'b0; l_req = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("sat_stall", f_stall_cnt, 15);

    // Reset during a loader write to 0x20 (word 16 holds 0x77).
    l_req = 1'b1; l_we = 1'b1; l_addr = 'h20; l_wdata = 'h99;
    step();
    l_req = 1'b0;
    @(negedge clk);
    chk("ra_mem_we", mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ra_mem_we_drop", mem_we, 0);
    chk("ra_l_gnt_drop", l_gnt, 0);
    chk("ra_mem_addr", mem_addr, 0);
    chk("ra_mem_wdata", mem_wdata, 0);
    chk("ra_stall", f_stall_cnt, 0);
    chk("ra_f_rdata", f_rdata, 0);
    chk("ra_l_rdata", l_rdata, 0);
    step();
    chk("ra_mem_word", mem[16], 'h77);
    chk("ra_no_done0", l_done, 0);
    rst_n = 1'b1;
    l_we = 1'b0;
    @(negedge clk);
    chk("ra_no_done1", l_done, 0);
    step();
    @(negedge clk);
    chk("ra_no_done2", l_done, 0);
    chk("ra_mem_word2", mem[16], 'h77);

    // Contention from reset: fetch wins first, then grants alternate.
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 'h4; f_addr = 'h10;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
        @(negedge clk);
      end
      chk($sformatf("ct_f_gnt%0d", i), f_gnt, ct_fgnt[i]);
      chk($sformatf("ct_l_gnt%0d", i), l_gnt, ct_lgnt[i]);
      chk($sformatf("ct_f_done%0d", i), f_done, ct_fdone[i]);
      chk($sformatf("ct_l_done%0d", i), l_done, ct_ldone[i]);
      chk($sformatf("ct_stall%0d", i), f_stall_cnt, ct_stall[i]);
      if (i == 2) chk("ct_f_rdata", f_rdata, 'h55);
      if (i == 4) chk("ct_l_rdata", l_rdata, 'hABCD);
    end
    step();
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    chk("ct_l_done8", l_done, 1);
    chk("ct_l_rdata8", l_rdata, 'hABCD);
    chk("ct_f_gnt8", f_gnt, 0);
    chk("ct_stall8", f_stall_cnt, 6);

`ifdef IMEM_ARB_LOCK_EN
    step();
    @(negedge clk);
    l_lock = 1'b1; f_req = 1'b1; l_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        step();
        @(negedge clk);
      end
      chk($sformatf("lk_f_gnt%0d", i), f_gnt, 0);
      chk($sformatf("lk_l_gnt%0d", i), l_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("lk_stall%0d", i), f_stall_cnt, 6 + i);
    end
    step();
    l_lock = 1'b0;
    @(negedge clk);
    chk("lk_f_gnt6", f_gnt, 0);
    step();
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    chk("lk_f_gnt7", f_gnt, 1);
    chk("lk_l_gnt7", l_gnt, 0);
    chk("lk_stall7", f_stall_cnt, 13);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
